// File: rtl/rr_multi_grant_pkg.sv
`timescale 1ns/1ps
// Shared defaults for the round-robin multi-grant arbiter and its ordering helper.
package rr_multi_grant_pkg;

   localparam int DEF_ITEM_NUM  = 8;
   localparam int DEF_GRANT_NUM = 2;

endpackage

// File: rtl/rr_multi_grant_list_enabled_item_id.sv
`timescale 1ns/1ps
// Lists the ids of the set bits of seq in circular order starting at start_pos.
// Only the first OUT_NUM ids are produced; unused entries read as zero.
module list_enabled_item_id
   import rr_multi_grant_pkg::*;
#(
   parameter  int ITEM_NUM = DEF_ITEM_NUM,
   parameter  int OUT_NUM  = ITEM_NUM,
   localparam int ID_W     = $clog2(ITEM_NUM)
) (
   input  logic [ITEM_NUM-1:0]          seq,
   input  logic [ID_W-1:0]              start_pos,
   output logic [OUT_NUM-1:0][ID_W-1:0] item_id
);

   always_comb begin
      logic [ID_W-1:0] pos;
      int              rank;
      item_id = '0;
      pos     = '0;
      rank    = 0;
      for (int j = 0; j < ITEM_NUM; j++) begin
         // natural ID_W-bit overflow gives the modulo-ITEM_NUM wrap
         pos = start_pos + ID_W'(j);
         if (seq[pos] && (rank < OUT_NUM)) begin
            item_id[rank] = pos;
            rank          = rank + 1;
         end
      end
   end

endmodule

// File: rtl/rr_multi_grant.sv
`timescale 1ns/1ps
// Round-robin arbiter granting up to GRANT_NUM requesters per cycle from a rotating pointer,
// presented on a registered valid/ready stage that accepts all valid slots at once.
module rr_multi_grant
   import rr_multi_grant_pkg::*;
#(
   parameter  int ITEM_NUM  = DEF_ITEM_NUM,
   parameter  int GRANT_NUM = DEF_GRANT_NUM,
   localparam int ID_W      = $clog2(ITEM_NUM),
   localparam int CNT_W     = ID_W + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [ITEM_NUM-1:0]            req,
   output logic [ITEM_NUM-1:0]            req_ack,
   output logic [GRANT_NUM-1:0]           grant_valid,
   output logic [GRANT_NUM-1:0][ID_W-1:0] grant_id,
   input  logic                           grant_ready,
   output logic [ID_W-1:0]                ptr_out
);

   logic                           accept;
   logic                           load;
   logic [ITEM_NUM-1:0]            eff;
   logic [GRANT_NUM-1:0][ID_W-1:0] order;
   logic [CNT_W-1:0]               pop;
   logic [CNT_W-1:0]               cnt;
   logic [GRANT_NUM-1:0]           vld_p0;
   logic [GRANT_NUM-1:0][ID_W-1:0] id_p0;
   logic [ID_W-1:0]                ptr_p0;
   logic [GRANT_NUM-1:0]           vld_p1;
   logic [GRANT_NUM-1:0][ID_W-1:0] id_p1;
   logic [ID_W-1:0]                ptr;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] n);
      return (n > CNT_W'(GRANT_NUM)) ? CNT_W'(GRANT_NUM) : n;
   endfunction

   assign grant_valid = vld_p1;
   assign grant_id    = id_p1;
   assign ptr_out     = ptr;
   assign accept      = (|vld_p1) & grant_ready;
   assign load        = ~(|vld_p1) | grant_ready;

   always_comb begin
      req_ack = '0;
      for (int k = 0; k < GRANT_NUM; k++)
         if (accept && vld_p1[k]) req_ack[id_p1[k]] = 1'b1;
   end

   // Masking just-accepted items keeps a requester that has not yet dropped req from a double grant
   assign eff = req & ~req_ack;

   list_enabled_item_id #(
      .ITEM_NUM (ITEM_NUM),
      .OUT_NUM  (GRANT_NUM)
   ) u_order (
      .seq       (eff),
      .start_pos (ptr),
      .item_id   (order)
   );

   // ---- stage p0: batch selection ----
   always_comb begin
      pop = '0;
      for (int i = 0; i < ITEM_NUM; i++) pop = pop + CNT_W'(eff[i]);
      cnt = sat_cnt(pop);
   end

   always_comb begin
      vld_p0 = '0;
      id_p0  = '0;
      ptr_p0 = ptr;
      for (int k = 0; k < GRANT_NUM; k++) begin
         if (CNT_W'(k) < cnt) begin
            vld_p0[k] = 1'b1;
            id_p0[k]  = order[k];
            ptr_p0    = order[k] + ID_W'(1);
         end
      end
   end

   // ---- stage p1: registered grant slots and pointer ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1 <= '0;
         id_p1  <= '0;
         ptr    <= '0;
      end else if (flush) begin
         vld_p1 <= '0;
      end else if (load) begin
         vld_p1 <= vld_p0;
         id_p1  <= id_p0;
         ptr    <= ptr_p0;
      end
   end

endmodule

// File: tb/tb_rr_multi_grant.sv
`timescale 1ns/1ps
// Scoreboard bench for rr_multi_grant: directed vectors with hand-computed batches,
// then a randomized phase driven by an ordered-list reference model.
module tb_rr_multi_grant;

   localparam int N            = 8;
   localparam int G            = 2;
   localparam int IW           = 3;
   localparam int STARVE_LIMIT = N / G + 1;
   localparam int RAND_CYCLES  = 3000;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             grant_ready;
   logic [N-1:0]     req;
   logic [N-1:0]     req_ack;
   logic [G-1:0]     grant_valid;
   logic [G-1:0][IW-1:0] grant_id;
   logic [IW-1:0]    ptr_out;

   typedef struct packed {
      logic [G-1:0]  vld;
      logic [IW-1:0] id0;
      logic [IW-1:0] id1;
      logic [IW-1:0] ptr;
      logic [N-1:0]  ack;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   rr_multi_grant #(.ITEM_NUM(N), .GRANT_NUM(G)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req         (req),
      .req_ack     (req_ack),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .grant_ready (grant_ready),
      .ptr_out     (ptr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [G-1:0] v, input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                       input logic [IW-1:0] p, input logic [N-1:0] a);
      exp_t e;
      e.vld = v; e.id0 = i0; e.id1 = i1; e.ptr = p; e.ack = a;
      sb_q.push_back(e);
   endtask

   task automatic chk_hold(input string name, input logic [G-1:0] v, input logic [IW-1:0] i0,
                           input logic [IW-1:0] i1, input logic [IW-1:0] p);
      chk({name, "_valid"}, 32'(grant_valid), 32'(v));
      chk({name, "_id0"},   32'(grant_id[0]), 32'(i0));
      chk({name, "_id1"},   32'(grant_id[1]), 32'(i1));
      chk({name, "_ptr"},   32'(ptr_out),     32'(p));
      chk({name, "_ack"},   32'(req_ack),     32'd0);
   endtask

   // Monitor: every accepted batch must match the oldest expected batch.
   always @(negedge clk) begin
      if (rst === 1'b1 && (|grant_valid) === 1'b1 && grant_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got valid=%b ids=%0d,%0d with no batch expected",
                     grant_valid, grant_id[0], grant_id[1]);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_valid", 32'(grant_valid), 32'(e.vld));
            chk("sb_id0",   32'(grant_id[0]), 32'(e.id0));
            chk("sb_id1",   32'(grant_id[1]), 32'(e.id1));
            chk("sb_ptr",   32'(ptr_out),     32'(e.ptr));
            chk("sb_ack",   32'(req_ack),     32'(e.ack));
            if (grant_valid == 2'b11)
               chk("sb_dup_id", 32'(grant_id[0] != grant_id[1]), 32'd1);
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [G-1:0]  m_valid, n_valid;
      logic [IW-1:0] m_id0, m_id1, m_ptr, n_id0, n_id1, n_ptr, p;
      logic [N-1:0]  m_ack, eff, nreq, hold_vec;
      bit            acc, ld, hit;
      int            cnt;
      int            wait_cnt [N];

      // reset with all requests high
      rst = 1'b0; flush = 1'b0; req = 8'hFF; grant_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", 32'(grant_valid), 32'd0);
      chk("rst_ptr",   32'(ptr_out),     32'd0);
      chk("rst_ack",   32'(req_ack),     32'd0);
      rst = 1'b1; req = '0;
      tick();
      chk("idle_valid", 32'(grant_valid), 32'd0);

      // basic two batches from ptr 0
      req = 8'b1010_0110; push(2'b11, 3'd1, 3'd2, 3'd3, 8'b0000_0110); tick();
      req = 8'b1010_0000; push(2'b11, 3'd5, 3'd7, 3'd0, 8'b1010_0000); tick();
      req = '0; tick();
      chk("basic_drain_valid", 32'(grant_valid), 32'd0);
      chk("basic_drain_ptr",   32'(ptr_out),     32'd0);

      // wrap: walk ptr to 6, then 6 -> 0 -> 1
      req = 8'b0010_0000; push(2'b01, 3'd5, 3'd0, 3'd6, 8'b0010_0000); tick();
      req = 8'b0100_0011; push(2'b11, 3'd6, 3'd0, 3'd1, 8'b0100_0001); tick();
      req = 8'b0000_0010; push(2'b01, 3'd1, 3'd0, 3'd2, 8'b0000_0010); tick();
      req = '0; tick();
      chk("wrap_drain_valid", 32'(grant_valid), 32'd0);
      chk("wrap_drain_ptr",   32'(ptr_out),     32'd2);

      // backpressure: batch {3,4} held while req changes
      grant_ready = 1'b0; req = 8'b0001_1000; tick();
      chk_hold("bp_load", 2'b11, 3'd3, 3'd4, 3'd5);
      for (int h = 0; h < 3; h++) begin
         hold_vec = (h == 0) ? 8'hFF : (h == 1) ? 8'h01 : 8'h80;
         req = hold_vec;
         tick();
         chk_hold("bp_hold", 2'b11, 3'd3, 3'd4, 3'd5);
      end
      grant_ready = 1'b1; req = 8'b1001_1000;
      push(2'b11, 3'd3, 3'd4, 3'd5, 8'b0001_1000);
      push(2'b01, 3'd7, 3'd0, 3'd0, 8'b1000_0000);
      tick();
      req = '0; tick();
      chk("bp_drain_valid", 32'(grant_valid), 32'd0);
      chk("bp_drain_ptr",   32'(ptr_out),     32'd0);

      // flush with an accepted batch, empty requests, flush over load
      grant_ready = 1'b0; req = 8'b0000_0011; tick();
      flush = 1'b1; grant_ready = 1'b1;
      push(2'b11, 3'd0, 3'd1, 3'd2, 8'b0000_0011);
      tick();
      chk("flush_valid", 32'(grant_valid), 32'd0);
      chk("flush_ptr",   32'(ptr_out),     32'd2);
      flush = 1'b0; req = '0; tick();
      chk("empty_valid", 32'(grant_valid), 32'd0);
      chk("empty_ptr",   32'(ptr_out),     32'd2);
      grant_ready = 1'b0; req = 8'b0000_0100; tick();
      flush = 1'b1; req = 8'b1000_0000; tick();
      chk("flush2_valid", 32'(grant_valid), 32'd0);
      chk("flush2_ptr",   32'(ptr_out),     32'd3);
      grant_ready = 1'b1; tick();
      chk("flush_over_load_valid", 32'(grant_valid), 32'd0);
      chk("flush_over_load_ptr",   32'(ptr_out),     32'd3);
      flush = 1'b0; push(2'b01, 3'd7, 3'd0, 3'd0, 8'b1000_0000); tick();
      req = '0; tick();
      tick();
      chk("flush_drain_valid", 32'(grant_valid), 32'd0);

      // randomized phase against the ordered-list model
      rst = 1'b0; tick(); rst = 1'b1;
      m_valid = '0; m_id0 = '0; m_id1 = '0; m_ptr = '0; nreq = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         grant_ready = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         req         = nreq;
         acc   = (m_valid != 0) && grant_ready;
         m_ack = '0;
         if (acc) begin
            if (m_valid[0]) m_ack[m_id0] = 1'b1;
            if (m_valid[1]) m_ack[m_id1] = 1'b1;
            push(m_valid, m_id0, m_id1, m_ptr, m_ack);
         end
         eff = req & ~m_ack;
         ld  = !flush && ((m_valid == 0) || grant_ready);
         n_valid = m_valid; n_id0 = m_id0; n_id1 = m_id1; n_ptr = m_ptr;
         if (flush) begin
            n_valid = '0;
         end else if (ld) begin
            n_valid = '0; n_id0 = '0; n_id1 = '0; cnt = 0;
            for (int i = 0; i < N; i++) begin
               p = m_ptr + 3'(i);
               if (eff[p] && cnt < G) begin
                  if (cnt == 0) n_id0 = p; else n_id1 = p;
                  n_valid[cnt] = 1'b1;
                  cnt++;
                  n_ptr = p + 3'd1;
               end
            end
         end
         tick();
         if (ld) begin
            for (int i = 0; i < N; i++) begin
               if (eff[i]) begin
                  hit = (grant_valid[0] && grant_id[0] == 3'(i)) ||
                        (grant_valid[1] && grant_id[1] == 3'(i));
                  if (hit) begin
                     n_chk++;
                     if (wait_cnt[i] > STARVE_LIMIT) begin
                        n_fail++;
                        $display("FAIL starve: item %0d waited %0d loads, limit %0d",
                                 i, wait_cnt[i], STARVE_LIMIT);
                     end
                     wait_cnt[i] = 0;
                  end else begin
                     wait_cnt[i]++;
                  end
               end
            end
         end
         m_valid = n_valid; m_id0 = n_id0; m_id1 = n_id1; m_ptr = n_ptr;
         nreq = (req | (N'($urandom) & N'($urandom))) & ~m_ack;
      end
      for (int i = 0; i < N; i++) begin
         if (wait_cnt[i] > STARVE_LIMIT) begin
            n_chk++;
            n_fail++;
            $display("FAIL starve_end: item %0d still waiting after %0d loads", i, wait_cnt[i]);
         end
      end

      // drop any loaded batch without accepting it
      grant_ready = 1'b0; flush = 1'b1; req = '0; tick();
      flush = 1'b0; tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
